cache_control: RTL
==================

// Module: cache_control
// PURPOSE
//  Write-back, direct-mapped cache controller FSM sequencing the L1 data/tag/valid/dirty arrays and the line datain merge path.
//  Serves single-word CPU reads/writes on hits.
//  On a miss: writes back a dirty victim line, then refills the line from physical memory.
//  Sits between the CPU-side mem_* interface and the pmem_* 256-bit line interface; drives array load enables and datain path select.
// PARAMETERS
//  CNT_WIDTH   32   width of performance counters (used only with CACHE_PERF_CNT_EN)
// PORTS
//  clk              in   1          rising-edge clock
//  rst              in   1          synchronous, active-high reset
//  mem_read         in   1          CPU read request, held until mem_resp
//  mem_write        in   1          CPU write request, held until mem_resp
//  hit              in   1          tag match AND valid for current index (from tag compare)
//  dirty            in   1          dirty bit of current index
//  pmem_resp        in   1          physical memory transaction done (1-cycle pulse)
//  mem_resp         out  1          CPU request complete (1-cycle pulse)
//  pmem_read        out  1          line read request, held until pmem_resp
//  pmem_write       out  1          line write request, held until pmem_resp
//  pmem_addr_sel    out  1          0 = {cpu tag,index}, 1 = {stored tag,index} (victim)
//  datain_hit       out  1          drives datain merge path hit input; 0 selects pmem_rdata line
//  load_data        out  1          write data array line this cycle
//  load_tag         out  1          write tag array
//  load_valid       out  1          set valid bit
//  load_dirty       out  1          write dirty bit
//  dirty_in         out  1          value written when load_dirty
//  hit_count        out  CNT_WIDTH  (CACHE_PERF_CNT_EN only) completed hits
//  miss_count       out  CNT_WIDTH  (CACHE_PERF_CNT_EN only) misses entering refill
//  wb_count         out  CNT_WIDTH  (CACHE_PERF_CNT_EN only) victim writebacks
// BEHAVIOUR
//  States: IDLE, WRITEBACK, ALLOCATE. Registered state; outputs combinational from state + inputs.
//  While rst=1: all outputs forced 0. Next edge: state=IDLE.
//  IDLE, no request: all outputs 0.
//  IDLE, req & hit:
//   - mem_resp=1 same cycle (0 wait states), datain_hit=1.
//   - Write hit also asserts load_data=1, load_dirty=1, dirty_in=1 (byte-merged word).
//   - Stay IDLE.
//  IDLE, req & ~hit & dirty: -> WRITEBACK.
//  IDLE, req & ~hit & ~dirty: -> ALLOCATE. No array writes, no mem_resp.
//  WRITEBACK: pmem_write=1, pmem_addr_sel=1. On pmem_resp -> ALLOCATE.
//  ALLOCATE: pmem_read=1, pmem_addr_sel=0, datain_hit=0.
//   - On pmem_resp: load_data, load_tag, load_valid, load_dirty=1 with dirty_in=0; -> IDLE.
//   - Request then hits in IDLE on the following cycle.
//  Miss latency = wb wait (if dirty) + refill wait + 1 hit cycle.
//  mem_read & mem_write both high: treated as write.
//  Request dropped mid-miss:
//   - Outstanding pmem transaction still completes; line still installed.
//   - IDLE then idles; no mem_resp.
//  pmem_resp in IDLE is ignored.
//  pmem_read and pmem_write never both high.
//  rst mid-WRITEBACK/ALLOCATE: pmem_* drop while rst=1, state=IDLE after the edge, no array write.
// CONFIGURATION
//  CACHE_PERF_CNT_EN defined:
//   - Instantiate counters and hit_count/miss_count/wb_count ports.
//   - hit_count: +1 per hit mem_resp. miss_count: +1 on IDLE->ALLOCATE or IDLE->WRITEBACK.
//   - wb_count: +1 on WRITEBACK pmem_resp.
//   - Counters saturate at all-ones; reset to 0.
//  Undefined: counters and ports absent; FSM identical.
// STRUCTURE
//  cache_types_pkg: cache_state_t enum {IDLE, WRITEBACK, ALLOCATE}, PMEM_ADDR_CPU/PMEM_ADDR_VICTIM constants.
//  Sub-module cache_perf_counters (three saturating CNT_WIDTH counters), instantiated only under CACHE_PERF_CNT_EN.
// TESTING
//  1. Read hit:
//     - Stimulus: mem_read=1, hit=1.
//     - Response: mem_resp=1 same cycle, load_data=0, state stays IDLE.
//  2. Write hit:
//     - Stimulus: mem_write=1, hit=1, dirty=0.
//     - Response: mem_resp, load_data, load_dirty, dirty_in all =1 in one cycle.
//  3. Clean read miss:
//     - Stimulus: hit=0, dirty=0; pmem_resp after 5 cycles; hit=1 afterwards.
//     - Response: pmem_read high 5 cycles, then load_data/tag/valid=1, dirty_in=0, mem_resp 1 cycle later.
//  4. Dirty write miss:
//     - Stimulus: hit=0, dirty=1; pmem_resp after 3 then 4 cycles.
//     - Response: pmem_write+addr_sel=1 for 3 cycles, pmem_read for 4 cycles, then write-hit cycle.
//     - CACHE_PERF_CNT_EN: miss_count=1, wb_count=1, hit_count=1.
//  5. rst mid-ALLOCATE:
//     - Stimulus: rst pulsed at cycle 2 of ALLOCATE.
//     - Response: pmem_read=0 that cycle, IDLE next, no load_*; counters=0.
//  6. Request dropped during WRITEBACK:
//     - Stimulus: mem_write deasserted during WRITEBACK.
//     - Response: writeback and refill complete, no mem_resp issued.

Source files
------------

// File: rtl/cache_types_pkg.sv
// Shared types for the direct-mapped write-back cache controller.
package cache_types_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } cache_state_t;

  localparam logic PMEM_ADDR_CPU    = 1'b0;
  localparam logic PMEM_ADDR_VICTIM = 1'b1;

endpackage

// File: rtl/cache_perf_counters.sv
// Three saturating event counters (hits, misses, victim writebacks).
module cache_perf_counters
  import cache_types_pkg::*;
#(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 hit_ev_i,
  input  logic                 miss_ev_i,
  input  logic                 wb_ev_i,
  output logic [CNT_WIDTH-1:0] hit_count_o,
  output logic [CNT_WIDTH-1:0] miss_count_o,
  output logic [CNT_WIDTH-1:0] wb_count_o
);

  logic [CNT_WIDTH-1:0] hit_q, hit_d;
  logic [CNT_WIDTH-1:0] miss_q, miss_d;
  logic [CNT_WIDTH-1:0] wb_q, wb_d;

  // Counters stick at all-ones rather than wrapping.
  always_comb begin
    hit_d  = hit_q;
    miss_d = miss_q;
    wb_d   = wb_q;
    if (hit_ev_i  && (hit_q  != '1)) hit_d  = hit_q  + 1'b1;
    if (miss_ev_i && (miss_q != '1)) miss_d = miss_q + 1'b1;
    if (wb_ev_i   && (wb_q   != '1)) wb_d   = wb_q   + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_q  <= '0;
      miss_q <= '0;
      wb_q   <= '0;
    end else begin
      hit_q  <= hit_d;
      miss_q <= miss_d;
      wb_q   <= wb_d;
    end
  end

  assign hit_count_o  = hit_q;
  assign miss_count_o = miss_q;
  assign wb_count_o   = wb_q;

endmodule

// File: rtl/cache_control.sv
// Write-back direct-mapped cache controller FSM (IDLE/WRITEBACK/ALLOCATE).
// Define CACHE_PERF_CNT_EN to add hit/miss/writeback performance counters.
module cache_control
  import cache_types_pkg::*;
#(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mem_read,
  input  logic                 mem_write,
  input  logic                 hit,
  input  logic                 dirty,
  input  logic                 pmem_resp,
  output logic                 mem_resp,
  output logic                 pmem_read,
  output logic                 pmem_write,
  output logic                 pmem_addr_sel,
  output logic                 datain_hit,
  output logic                 load_data,
  output logic                 load_tag,
  output logic                 load_valid,
  output logic                 load_dirty,
`ifdef CACHE_PERF_CNT_EN
  output logic                 dirty_in,
  output logic [CNT_WIDTH-1:0] hit_count,
  output logic [CNT_WIDTH-1:0] miss_count,
  output logic [CNT_WIDTH-1:0] wb_count
`else
  output logic                 dirty_in
`endif
);

  cache_state_t state_q, state_d;
  logic req, wr;

  // A simultaneous read and write is serviced as a write.
  assign req = mem_read | mem_write;
  assign wr  = mem_write;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    mem_resp      = 1'b0;
    pmem_read     = 1'b0;
    pmem_write    = 1'b0;
    pmem_addr_sel = PMEM_ADDR_CPU;
    datain_hit    = 1'b0;
    load_data     = 1'b0;
    load_tag      = 1'b0;
    load_valid    = 1'b0;
    load_dirty    = 1'b0;
    dirty_in      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          if (hit) begin
            mem_resp   = 1'b1;
            datain_hit = 1'b1;
            if (wr) begin
              load_data  = 1'b1;
              load_dirty = 1'b1;
              dirty_in   = 1'b1;
            end
          end else if (dirty) begin
            state_d = WRITEBACK;
          end else begin
            state_d = ALLOCATE;
          end
        end
      end
      WRITEBACK: begin
        pmem_write    = 1'b1;
        pmem_addr_sel = PMEM_ADDR_VICTIM;
        if (pmem_resp) state_d = ALLOCATE;
      end
      ALLOCATE: begin
        pmem_read = 1'b1;
        // Line is installed clean; the retried request then hits in IDLE.
        if (pmem_resp) begin
          load_data  = 1'b1;
          load_tag   = 1'b1;
          load_valid = 1'b1;
          load_dirty = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (rst) begin
      mem_resp      = 1'b0;
      pmem_read     = 1'b0;
      pmem_write    = 1'b0;
      pmem_addr_sel = 1'b0;
      datain_hit    = 1'b0;
      load_data     = 1'b0;
      load_tag      = 1'b0;
      load_valid    = 1'b0;
      load_dirty    = 1'b0;
      dirty_in      = 1'b0;
    end
  end

`ifdef CACHE_PERF_CNT_EN
  logic miss_ev, wb_ev;

  assign miss_ev = !rst && (state_q == IDLE) && (state_d != IDLE);
  assign wb_ev   = !rst && (state_q == WRITEBACK) && pmem_resp;

  cache_perf_counters #(.CNT_WIDTH(CNT_WIDTH)) u_perf (
    .clk          (clk),
    .rst          (rst),
    .hit_ev_i     (mem_resp),
    .miss_ev_i    (miss_ev),
    .wb_ev_i      (wb_ev),
    .hit_count_o  (hit_count),
    .miss_count_o (miss_count),
    .wb_count_o   (wb_count)
  );
`else
  // Counter width stays part of the interface in both builds.
  logic [CNT_WIDTH-1:0] unused_cnt_w;
  assign unused_cnt_w = '0;
`endif

endmodule
